// File: rtl/blk_mem_responder_pkg.sv
// Shared types and constants for the block memory responder.
//   MEM_BLK_SIZE     : block width in bits (multiple of 8)
//   MEM_DEPTH        : default number of stored blocks
//   MEM_LATENCY      : default request-to-ready latency in cycles
//   mem_resp_state_e : responder FSM states
//   mem_req_t        : block request (addr, valid, byte strobes rw, data)
package blk_mem_responder_pkg;

    localparam int MEM_BLK_SIZE = 128;
    localparam int MEM_DEPTH    = 1024;
    localparam int MEM_LATENCY  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_e;

    // rw is a byte-strobe mask; all-zero means a pure read.
    typedef struct packed {
        logic [31:0]               addr;
        logic                      valid;
        logic [MEM_BLK_SIZE/8-1:0] rw;
        logic [MEM_BLK_SIZE-1:0]   data;
    } mem_req_t;

endpackage

// File: rtl/blk_ram_bw.sv
// Single-port synchronous RAM, DEPTH x BLK_SIZE, with per-byte write enables.
// Write-first: on a write cycle rdata_o returns the merged (post-write) block.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (clears the read register only)
//   en_i    : access enable (read, plus write of strobed bytes)
//   addr_i  : block index
//   we_i    : per-byte write strobes
//   wdata_i : write data
//   rdata_o : registered read data, holds between accesses
module blk_ram_bw #(
    parameter int    BLK_SIZE  = 128,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   NB        = BLK_SIZE / 8,
    localparam int   IDX_W     = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [IDX_W-1:0]    addr_i,
    input  logic [NB-1:0]       we_i,
    input  logic [BLK_SIZE-1:0] wdata_i,
    output logic [BLK_SIZE-1:0] rdata_o
);

    logic [BLK_SIZE-1:0] mem_q [DEPTH];
    logic [BLK_SIZE-1:0] merged;
    logic [BLK_SIZE-1:0] rdata_q;

    // Old block with newly strobed bytes overlaid.
    always_comb begin
        merged = mem_q[addr_i];
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) merged[i*8 +: 8] = wdata_i[i*8 +: 8];
        end
    end

    // Storage has no reset; kept in its own block so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < NB; i++) begin
                if (we_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (en_i) rdata_q <= merged;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/blk_mem_responder.sv
// Memory-side responder for the mem_req_t block interface. Accepts one read
// or byte-strobed write, holds it LATENCY cycles, then commits the write and
// returns the post-write block with a one-cycle mem_ready_o pulse.
//   clk_i         : clock
//   rst_ni        : synchronous active-low reset
//   mem_req_i     : request (addr, valid, rw byte strobes, data)
//   mem_ready_o   : one-cycle response strobe
//   iomem_rdata_o : response block, qualify with mem_ready_o
// BLK_SIZE must match the package block width since mem_req_t is fixed.
module blk_mem_responder
    import blk_mem_responder_pkg::*;
#(
    parameter int    BLK_SIZE  = MEM_BLK_SIZE,
    parameter int    DEPTH     = MEM_DEPTH,
    parameter int    LATENCY   = MEM_LATENCY,
    parameter string INIT_FILE = ""
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  mem_req_t            mem_req_i,
    output logic                mem_ready_o,
    output logic [BLK_SIZE-1:0] iomem_rdata_o
);

    localparam int NB      = BLK_SIZE / 8;
    localparam int BOFFSET = $clog2(NB);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] IDX_MASK = 32'((DEPTH - 1) << BOFFSET);

    mem_resp_state_e     state_q;
    logic [7:0]          cnt_q;
    logic                ready_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NB-1:0]       rw_q;
    logic [BLK_SIZE-1:0] data_q;

    logic                ram_en;
    logic [IDX_W-1:0]    ram_addr;
    logic [NB-1:0]       ram_we;
    logic [BLK_SIZE-1:0] ram_wdata;
    logic                unused_addr;

    // Offset and upper address bits are don't-care (aliasing is intended).
    assign unused_addr = ^(mem_req_i.addr & ~IDX_MASK);

    // The RAM access happens on the edge entering RESP. With LATENCY==1 that
    // edge is the accept edge itself, so the live request feeds the RAM.
    // Gating with rst_ni keeps a reset edge from committing a write.
    always_comb begin
        ram_en    = 1'b0;
        ram_addr  = idx_q;
        ram_we    = rw_q;
        ram_wdata = data_q;
        if (state_q == IDLE) begin
            ram_addr  = mem_req_i.addr[BOFFSET +: IDX_W];
            ram_we    = mem_req_i.rw;
            ram_wdata = mem_req_i.data;
            ram_en    = rst_ni && mem_req_i.valid && (LATENCY == 1);
        end else if (state_q == WAIT) begin
            ram_en    = rst_ni && (cnt_q == 8'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (mem_req_i.valid) begin
                        idx_q  <= mem_req_i.addr[BOFFSET +: IDX_W];
                        rw_q   <= mem_req_i.rw;
                        data_q <= mem_req_i.data;
                        cnt_q  <= 8'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    blk_ram_bw #(
        .BLK_SIZE (BLK_SIZE),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (ram_en),
        .addr_i (ram_addr),
        .we_i   (ram_we),
        .wdata_i(ram_wdata),
        .rdata_o(iomem_rdata_o)
    );

    assign mem_ready_o = ready_q;

endmodule
